// File: rtl/fifo_dsz_pkg.sv
// Shared types and default parameters for the FIFO downsizer.
package fifo_dsz_pkg;

    typedef enum logic {
        LANE_LSB_FIRST = 1'b0,
        LANE_MSB_FIRST = 1'b1
    } lane_order_e;

    localparam int unsigned DEF_WIDTH_OUT = 8;
    localparam int unsigned DEF_RATIO     = 4;
    localparam int unsigned DEF_DEPTH     = 16;
    localparam bit          DEF_LSB_FIRST = 1'b1;
    localparam int unsigned DEF_AF_MARGIN = 2;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_dsz_mem.sv
// Word storage for the downsizer: synchronous write, combinational read, no reset.
module fifo_dsz_mem #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 35
) (
    input  logic                     clk,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_c_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_downsizer.sv
// Wide-to-narrow FIFO: stores input words with a valid lane count and emits
// one WIDTH_OUT lane per accepted read, in configurable lane order.
module fifo_downsizer
    import fifo_dsz_pkg::*;
#(
    parameter int unsigned WIDTH_OUT = DEF_WIDTH_OUT,
    parameter int unsigned RATIO     = DEF_RATIO,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter bit          LSB_FIRST = DEF_LSB_FIRST,
    parameter int unsigned AF_MARGIN = DEF_AF_MARGIN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en_i,
    input  logic [RATIO*WIDTH_OUT-1:0]   data_in_i,
    input  logic [$clog2(RATIO):0]       wr_lanes_i,
    input  logic                         rd_en_i,
    input  logic                         flush_i,
    output logic [WIDTH_OUT-1:0]         data_out_o,
    output logic                         dout_valid_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic [$clog2(DEPTH+1)-1:0]   word_count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int unsigned WIDTH_IN = RATIO * WIDTH_OUT;
    localparam int unsigned LANE_W   = $clog2(RATIO) + 1;
    localparam int unsigned IDX_W    = idx_width(RATIO);
    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1);
    localparam int unsigned AF_TH    = (AF_MARGIN < DEPTH) ? DEPTH - AF_MARGIN : 0;
    localparam lane_order_e ORDER    = LSB_FIRST ? LANE_LSB_FIRST : LANE_MSB_FIRST;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]     lane_idx_q, lane_idx_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [WIDTH_OUT-1:0] data_out_q, data_out_d;
    logic                 dout_valid_q, dout_valid_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 af_q, af_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    logic [LANE_W-1:0]    wr_lanes_eff;
    logic [LANE_W-1:0]    head_lanes;
    logic [WIDTH_IN-1:0]  head_data;
    logic [IDX_W-1:0]     lane_sel;
    logic [WIDTH_OUT-1:0] lane_data;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 retire;

    // Zero or out-of-range lane counts mean a fully populated word.
    always_comb begin
        wr_lanes_eff = wr_lanes_i;
        if ((wr_lanes_i == '0) || (wr_lanes_i > LANE_W'(RATIO))) begin
            wr_lanes_eff = LANE_W'(RATIO);
        end
    end

    assign wr_acc = wr_en_i & ~full_q & ~flush_i;
    assign rd_acc = rd_en_i & ~empty_q & ~flush_i;

    fifo_dsz_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH_IN + LANE_W)
    ) u_mem (
        .clk         (clk),
        .wr_en_i     (wr_acc),
        .wr_addr_i   (wr_ptr_q),
        .wr_data_i   ({wr_lanes_eff, data_in_i}),
        .rd_addr_i   (rd_ptr_q),
        .rd_data_c_o ({head_lanes, head_data})
    );

    // Valid lanes are always the low lanes; MSB-first walks them downward.
    always_comb begin
        if (ORDER == LANE_LSB_FIRST) begin
            lane_sel = lane_idx_q;
        end else begin
            lane_sel = IDX_W'(head_lanes - LANE_W'(1) - LANE_W'(lane_idx_q));
        end
        lane_data = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane_sel == IDX_W'(i)) begin
                lane_data = head_data[i*WIDTH_OUT +: WIDTH_OUT];
            end
        end
    end

    assign retire = rd_acc && ((LANE_W'(lane_idx_q) + LANE_W'(1)) == head_lanes);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        lane_idx_d   = lane_idx_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        dout_valid_d = rd_acc;
        ovf_d        = ovf_q | (wr_en_i & full_q & ~flush_i);
        unf_d        = unf_q | (rd_en_i & empty_q & ~flush_i);

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_acc) begin
            data_out_d = lane_data;
            if (retire) begin
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                lane_idx_d = '0;
            end else begin
                lane_idx_d = lane_idx_q + IDX_W'(1);
            end
        end
        case ({wr_acc, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            lane_idx_d = '0;
            count_d    = '0;
        end

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= CNT_W'(AF_TH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            lane_idx_q   <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            dout_valid_q <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            af_q         <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            lane_idx_q   <= lane_idx_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            dout_valid_q <= dout_valid_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            af_q         <= af_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

    assign data_out_o    = data_out_q;
    assign dout_valid_o  = dout_valid_q;
    assign full_o        = full_q;
    assign empty_o       = empty_q;
    assign almost_full_o = af_q;
    assign word_count_o  = count_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = unf_q;

endmodule

// File: tb/tb_fifo_downsizer.sv
// Bench for fifo_downsizer: LSB-first and MSB-first instances share one
// stimulus stream and are checked against a queue model every cycle.
module tb_fifo_downsizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] din = '0;
    logic [2:0]  wl = '0;
    logic        rd_en = 1'b0;
    logic        flush = 1'b0;

    logic [7:0] dl_do, dm_do;
    logic       dl_dv, dm_dv, dl_full, dm_full, dl_empty, dm_empty, dl_af, dm_af;
    logic [4:0] dl_wc, dm_wc;
    logic       dl_ovf, dm_ovf, dl_unf, dm_unf;

    always #5 clk = ~clk;

    fifo_downsizer dut_l (
        .clk (clk), .rst (rst), .wr_en_i (wr_en), .data_in_i (din), .wr_lanes_i (wl),
        .rd_en_i (rd_en), .flush_i (flush), .data_out_o (dl_do), .dout_valid_o (dl_dv),
        .full_o (dl_full), .empty_o (dl_empty), .almost_full_o (dl_af),
        .word_count_o (dl_wc), .overflow_o (dl_ovf), .underflow_o (dl_unf)
    );

    fifo_downsizer #(.LSB_FIRST (1'b0)) dut_m (
        .clk (clk), .rst (rst), .wr_en_i (wr_en), .data_in_i (din), .wr_lanes_i (wl),
        .rd_en_i (rd_en), .flush_i (flush), .data_out_o (dm_do), .dout_valid_o (dm_dv),
        .full_o (dm_full), .empty_o (dm_empty), .almost_full_o (dm_af),
        .word_count_o (dm_wc), .overflow_o (dm_ovf), .underflow_o (dm_unf)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lane_of(input logic [31:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    // Behavioural model: a queue of words, each consumed lane by lane.
    logic [31:0] q_data[$];
    int          q_lanes[$];
    int          m_idx, m_n;
    bit          m_wacc, m_racc;
    logic [7:0]  m_do_l, m_do_m;
    logic        m_dv, m_ovf, m_unf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data.delete();
            q_lanes.delete();
            m_idx = 0;
            m_do_l = '0;
            m_do_m = '0;
            m_dv = 1'b0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_n = q_data.size();
            m_wacc = wr_en && !flush && (m_n < 16);
            m_racc = rd_en && !flush && (m_n > 0);
            if (wr_en && !flush && m_n == 16) m_ovf = 1'b1;
            if (rd_en && !flush && m_n == 0) m_unf = 1'b1;
            m_dv = m_racc;
            if (flush) begin
                q_data.delete();
                q_lanes.delete();
                m_idx = 0;
            end else begin
                if (m_racc) begin
                    m_do_l = lane_of(q_data[0], m_idx);
                    m_do_m = lane_of(q_data[0], q_lanes[0] - 1 - m_idx);
                    m_idx++;
                    if (m_idx == q_lanes[0]) begin
                        void'(q_data.pop_front());
                        void'(q_lanes.pop_front());
                        m_idx = 0;
                    end
                end
                if (m_wacc) begin
                    q_data.push_back(din);
                    q_lanes.push_back((wl == 0 || wl > 4) ? 4 : int'(wl));
                end
            end
        end
    end

    logic [7:0] cap_l[$];
    logic [7:0] cap_m[$];

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("l_data_out",   32'(dl_do),    32'(m_do_l));
        chk("m_data_out",   32'(dm_do),    32'(m_do_m));
        chk("l_dout_valid", 32'(dl_dv),    32'(m_dv));
        chk("m_dout_valid", 32'(dm_dv),    32'(m_dv));
        chk("l_empty",      32'(dl_empty), 32'(q_data.size() == 0));
        chk("m_empty",      32'(dm_empty), 32'(q_data.size() == 0));
        chk("l_full",       32'(dl_full),  32'(q_data.size() == 16));
        chk("m_full",       32'(dm_full),  32'(q_data.size() == 16));
        chk("l_afull",      32'(dl_af),    32'(q_data.size() >= 14));
        chk("m_afull",      32'(dm_af),    32'(q_data.size() >= 14));
        chk("l_word_count", 32'(dl_wc),    32'(q_data.size()));
        chk("m_word_count", 32'(dm_wc),    32'(q_data.size()));
        chk("l_overflow",   32'(dl_ovf),   32'(m_ovf));
        chk("m_overflow",   32'(dm_ovf),   32'(m_ovf));
        chk("l_underflow",  32'(dl_unf),   32'(m_unf));
        chk("m_underflow",  32'(dm_unf),   32'(m_unf));
        if (dl_dv) cap_l.push_back(dl_do);
        if (dm_dv) cap_m.push_back(dm_do);
    end

    task automatic step(input logic w, input logic [31:0] d, input logic [2:0] l,
                        input logic r, input logic f);
        wr_en = w; din = d; wl = l; rd_en = r; flush = f;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        step(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
    endtask

    task automatic cmp_caps(input string name, input logic [7:0] got[$], input logic [7:0] exp[$]);
        chk({name, "_count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk(name, 32'(got[i]), 32'(exp[i]));
        end
    endtask

    task automatic chk_reset_values();
        chk("rst_data_out",   32'(dl_do),    32'h0);
        chk("rst_dout_valid", 32'(dl_dv),    32'h0);
        chk("rst_empty",      32'(dl_empty), 32'h1);
        chk("rst_full",       32'(dl_full),  32'h0);
        chk("rst_afull",      32'(dl_af),    32'h0);
        chk("rst_word_count", 32'(dl_wc),    32'h0);
        chk("rst_overflow",   32'(dl_ovf),   32'h0);
        chk("rst_underflow",  32'(dl_unf),   32'h0);
        chk("rst_m_data_out", 32'(dm_do),    32'h0);
        chk("rst_m_valid",    32'(dm_dv),    32'h0);
    endtask

    logic [7:0] exp_l[$];
    logic [7:0] exp_m[$];

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk_reset_values();
        rst = 1'b0;
        idle();

        // Single full word, both lane orders.
        step(1'b1, 32'hA1B2C3D4, 3'd4, 1'b0, 1'b0);
        repeat (4) rd();
        idle();
        exp_l = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        exp_m = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        cmp_caps("order_lsb", cap_l, exp_l);
        cmp_caps("order_msb", cap_m, exp_m);
        chk("single_empty", 32'(dl_empty), 32'h1);
        chk("single_wc",    32'(dl_wc),    32'h0);
        cap_l.delete(); cap_m.delete();

        // Partial word followed by a lane count of zero, then underflow.
        step(1'b1, 32'h11223344, 3'd2, 1'b0, 1'b0);
        step(1'b1, 32'h55667788, 3'd0, 1'b0, 1'b0);
        repeat (6) rd();
        rd();
        chk("uf_valid",     32'(dl_dv),  32'h0);
        chk("uf_underflow", 32'(dl_unf), 32'h1);
        chk("uf_m_underflow", 32'(dm_unf), 32'h1);
        idle();
        exp_l = '{8'h44, 8'h33, 8'h88, 8'h77, 8'h66, 8'h55};
        exp_m = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        cmp_caps("partial_lsb", cap_l, exp_l);
        cmp_caps("partial_msb", cap_m, exp_m);
        cap_l.delete(); cap_m.delete();

        // Fill to full, overflow, then drain across the pointer wrap.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)}, 3'd4, 1'b0, 1'b0);
            chk("fill_afull", 32'(dl_af), 32'(i + 1 >= 14));
        end
        chk("fill_full", 32'(dl_full), 32'h1);
        chk("fill_wc",   32'(dl_wc),   32'd16);
        step(1'b1, 32'hDEADBEEF, 3'd4, 1'b0, 1'b0);
        chk("ovf_flag", 32'(dl_ovf), 32'h1);
        chk("ovf_wc",   32'(dl_wc),  32'd16);
        repeat (64) rd();
        idle();
        exp_l.delete(); exp_m.delete();
        for (int k = 0; k < 64; k++) begin
            exp_l.push_back(8'(k));
            exp_m.push_back(8'(4*(k/4) + 3 - (k%4)));
        end
        cmp_caps("drain_lsb", cap_l, exp_l);
        cmp_caps("drain_msb", cap_m, exp_m);
        chk("drain_empty", 32'(dl_empty), 32'h1);
        cap_l.delete(); cap_m.delete();

        // Flush mid-word with a competing write and read.
        step(1'b1, 32'h04030201, 3'd4, 1'b0, 1'b0);
        rd();
        rd();
        step(1'b1, 32'hDEADBEEF, 3'd4, 1'b1, 1'b1);
        chk("flush_empty", 32'(dl_empty), 32'h1);
        chk("flush_wc",    32'(dl_wc),    32'h0);
        chk("flush_valid", 32'(dl_dv),    32'h0);
        cap_l.delete(); cap_m.delete();
        step(1'b1, 32'hCAFEF00D, 3'd4, 1'b0, 1'b0);
        repeat (4) rd();
        idle();
        exp_l = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        exp_m = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        cmp_caps("post_flush_lsb", cap_l, exp_l);
        cmp_caps("post_flush_msb", cap_m, exp_m);

        // Asynchronous reset between lanes of a word.
        step(1'b1, 32'h44332211, 3'd4, 1'b0, 1'b0);
        rd();
        #2 rst = 1'b1;
        #1 chk_reset_values();
        @(negedge clk);
        #1 rst = 1'b0;
        cap_l.delete(); cap_m.delete();
        step(1'b1, 32'h87654321, 3'd4, 1'b0, 1'b0);
        repeat (4) rd();
        idle();
        exp_l = '{8'h21, 8'h43, 8'h65, 8'h87};
        exp_m = '{8'h87, 8'h65, 8'h43, 8'h21};
        cmp_caps("post_rst_lsb", cap_l, exp_l);
        cmp_caps("post_rst_msb", cap_m, exp_m);
        chk("post_rst_empty", 32'(dl_empty), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
